// File: rtl/keccak_digest_reader_if.sv
// Stream side of the keccak digest reader: one word per valid/ready transfer.
//   out_data  : stream word (driven by master)
//   out_valid : out_data holds a word (driven by master)
//   out_last  : marks the final word of the digest (driven by master)
//   out_ready : downstream accepts the word this cycle (driven by slave)
interface keccak_digest_reader_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/keccak_digest_reader.sv
// Captures the keccak core's digest into a local buffer. The buffer can be read
// at random by word index or streamed out word by word over a valid/ready link.
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   digest_in      : digest from the core, word 0 = most significant word
//   digest_valid   : one-cycle pulse, digest_in valid
//   hash_num       : random-access word index; rd_data follows one clock later
//   rd_data        : selected buffer word, 0 for indices past the last word
//   have_digest    : buffer holds a valid digest
//   stream_start   : pulse, start streaming the held digest
//   clear          : pulse, drop the digest and clear overrun
//   stream         : stream interface (out_data/out_valid/out_last/out_ready)
//   busy           : stream in progress
//   overrun        : sticky, a digest arrived during a stream and was dropped
module keccak_digest_reader #(
    parameter int unsigned DIGEST_W  = 512,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = DIGEST_W / WORD_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGEST_W-1:0]           digest_in,
    input  logic                          digest_valid,
    input  logic [4:0]                    hash_num,
    output logic [WORD_W-1:0]             rd_data,
    output logic                          have_digest,
    input  logic                          stream_start,
    input  logic                          clear,
    keccak_digest_reader_if.master        stream,
    output logic                          busy,
    output logic                          overrun
);
    localparam int unsigned CNT_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {EMPTY, HELD, STREAM} state_e;

    state_e              state_q;
    logic [DIGEST_W-1:0] buffer_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [WORD_W-1:0]   rd_data_q;
    logic [WORD_W-1:0]   rd_data_d;
    logic [WORD_W-1:0]   data_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                have_q;
    logic                overrun_q;

    logic [WORD_W-1:0]   buf_words [NUM_WORDS];

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
        assign buf_words[g] = buffer_q[DIGEST_W-1-g*WORD_W -: WORD_W];
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        rd_data_d = '0;
        if ({1'b0, hash_num} < 6'(NUM_WORDS)) begin
            rd_data_d = buf_words[hash_num[CNT_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            buffer_q  <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            have_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Random-access port runs every cycle regardless of state.
            rd_data_q <= rd_data_d;

            if (clear) begin
                state_q   <= EMPTY;
                buffer_q  <= '0;
                cnt_q     <= '0;
                data_q    <= '0;
                valid_q   <= 1'b0;
                last_q    <= 1'b0;
                busy_q    <= 1'b0;
                have_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (digest_valid) begin
                            buffer_q <= digest_in;
                            have_q   <= 1'b1;
                            state_q  <= HELD;
                        end
                    end
                    HELD: begin
                        if (digest_valid) begin
                            buffer_q <= digest_in;
                        end
                        if (stream_start) begin
                            state_q <= STREAM;
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            last_q  <= (NUM_WORDS == 1);
                            // A digest captured this same cycle is the one streamed.
                            data_q  <= digest_valid ? digest_in[DIGEST_W-1 -: WORD_W]
                                                    : buf_words[0];
                        end
                    end
                    STREAM: begin
                        if (digest_valid) begin
                            overrun_q <= 1'b1;
                        end
                        // out_valid is always high in this state.
                        if (stream.out_ready) begin
                            cnt_q <= cnt_d;
                            if (last_q) begin
                                state_q <= HELD;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                data_q  <= '0;
                            end else begin
                                data_q <= buf_words[cnt_d];
                                last_q <= (cnt_d == LAST_IDX);
                            end
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign rd_data          = rd_data_q;
    assign have_digest      = have_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
    assign stream.out_data  = data_q;
    assign stream.out_valid = valid_q;
    assign stream.out_last  = last_q;
endmodule

// File: tb/tb_keccak_digest_reader.sv
module tb_keccak_digest_reader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] digest_in = '0;
    logic         digest_valid = 1'b0;
    logic [4:0]   hash_num = '0;
    logic [31:0]  rd_data;
    logic         have_digest;
    logic         stream_start = 1'b0;
    logic         clear = 1'b0;
    logic         busy;
    logic         overrun;

    keccak_digest_reader_if #(.WORD_W(32)) sif ();

    keccak_digest_reader #(
        .DIGEST_W(512),
        .WORD_W(32),
        .NUM_WORDS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digest_in(digest_in),
        .digest_valid(digest_valid),
        .hash_num(hash_num),
        .rd_data(rd_data),
        .have_digest(have_digest),
        .stream_start(stream_start),
        .clear(clear),
        .stream(sif),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: buffer as an array of words, stream as a queue of
    // words still owed to the downstream side.
    logic [31:0] m_buf [16];
    bit          m_have;
    bit          m_ovr;
    logic [31:0] m_q [$];
    logic [31:0] m_rd;

    logic [31:0] log_d [$];
    bit          log_l [$];

    logic [511:0] FOX;
    logic [31:0]  fox_w [16];

    typedef struct {
        logic [4:0]  hash;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl [19];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void split_digest(input logic [511:0] d, output logic [31:0] w [16]);
        logic [511:0] t;
        t = d;
        for (int i = 0; i < 16; i++) begin
            w[i] = t[511:480];
            t = t << 32;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_buf[i] = '0;
        m_have = 0;
        m_ovr  = 0;
        m_q.delete();
        m_rd   = '0;
    endfunction

    function automatic void model_tick();
        logic [31:0] rd_n;
        bit          had;
        rd_n = (int'(hash_num) < 16) ? m_buf[hash_num[3:0]] : '0;
        had  = m_have;
        if (clear) begin
            for (int i = 0; i < 16; i++) m_buf[i] = '0;
            m_have = 0;
            m_ovr  = 0;
            m_q.delete();
        end else if (m_q.size() != 0) begin
            if (digest_valid) m_ovr = 1;
            if (sif.out_ready) void'(m_q.pop_front());
        end else begin
            if (digest_valid) begin
                split_digest(digest_in, m_buf);
                m_have = 1;
            end
            if (stream_start && had) begin
                for (int i = 0; i < 16; i++) m_q.push_back(m_buf[i]);
            end
        end
        m_rd = rd_n;
    endfunction

    task automatic check_all();
        chk32("rd_data", rd_data, m_rd);
        chk1("have_digest", have_digest, m_have);
        chk1("overrun", overrun, m_ovr);
        chk1("out_valid", sif.out_valid, m_q.size() != 0);
        chk1("busy", busy, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk32("out_data", sif.out_data, m_q[0]);
            chk1("out_last", sif.out_last, m_q.size() == 1);
        end
    endtask

    task automatic cycle();
        if (sif.out_valid && sif.out_ready) begin
            log_d.push_back(sif.out_data);
            log_l.push_back(sif.out_last);
        end
        model_tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic load(input logic [511:0] d);
        digest_in    = d;
        digest_valid = 1'b1;
        cycle();
        digest_valid = 1'b0;
    endtask

    task automatic start_stream();
        log_d.delete();
        log_l.delete();
        stream_start = 1'b1;
        cycle();
        stream_start = 1'b0;
    endtask

    // Drives out_ready (constant 1, or the 1,0,0,1 pattern) until the stream
    // ends or stop_at words have transferred; the loop is bounded.
    task automatic run_stream(input bit toggle, input int stop_at);
        int k;
        k = 0;
        while (busy && k < 200 && !(stop_at > 0 && log_d.size() >= stop_at)) begin
            sif.out_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            cycle();
            k++;
        end
        sif.out_ready = 1'b0;
        chk1("stream_bound", k < 200, 1'b1);
    endtask

    task automatic check_fox_log(input string name);
        chk32({name, "_count"}, 32'(log_d.size()), 32'd16);
        for (int i = 0; i < log_d.size() && i < 16; i++) begin
            chk32({name, "_word"}, log_d[i], fox_w[i]);
            chk1({name, "_last"}, log_l[i], i == 15);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] first_run [$];
        logic [511:0] rnd;

        FOX = 512'h18f4f4bd419603f95538837003d9d254c26c23765565162247483f65c50303597bc9ce4d289f21d1c2f1f458828e33dc442100331b35e7eb031b5d38ba6460f8;
        split_digest(FOX, fox_w);

        tbl[0]  = '{5'd0,  32'h18f4f4bd};
        tbl[1]  = '{5'd1,  32'h419603f9};
        tbl[2]  = '{5'd2,  32'h55388370};
        tbl[3]  = '{5'd3,  32'h03d9d254};
        tbl[4]  = '{5'd4,  32'hc26c2376};
        tbl[5]  = '{5'd5,  32'h55651622};
        tbl[6]  = '{5'd6,  32'h47483f65};
        tbl[7]  = '{5'd7,  32'hc5030359};
        tbl[8]  = '{5'd8,  32'h7bc9ce4d};
        tbl[9]  = '{5'd9,  32'h289f21d1};
        tbl[10] = '{5'd10, 32'hc2f1f458};
        tbl[11] = '{5'd11, 32'h828e33dc};
        tbl[12] = '{5'd12, 32'h44210033};
        tbl[13] = '{5'd13, 32'h1b35e7eb};
        tbl[14] = '{5'd14, 32'h031b5d38};
        tbl[15] = '{5'd15, 32'hba6460f8};
        tbl[16] = '{5'd16, 32'h00000000};
        tbl[17] = '{5'd20, 32'h00000000};
        tbl[18] = '{5'd31, 32'h00000000};

        sif.out_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        chk32("reset_out_data", sif.out_data, 32'h0);
        chk1("reset_out_last", sif.out_last, 1'b0);
        for (int i = 0; i < 32; i++) begin
            hash_num = 5'(i);
            cycle();
            chk32("reset_rd", rd_data, 32'h0);
        end

        // Capture and random-access table
        load(FOX);
        for (int i = 0; i < 19; i++) begin
            hash_num = tbl[i].hash;
            cycle();
            chk32("rd_tbl", rd_data, tbl[i].exp);
        end

        // Stream with out_ready held high
        start_stream();
        run_stream(1'b0, 0);
        check_fox_log("stream_rdy");
        chk1("after_stream_busy", busy, 1'b0);
        chk1("after_stream_have", have_digest, 1'b1);

        // Stream with out_ready 1,0,0,1,...; then replay
        start_stream();
        run_stream(1'b1, 0);
        check_fox_log("stream_tog");
        first_run = log_d;
        start_stream();
        run_stream(1'b1, 0);
        check_fox_log("replay");
        for (int i = 0; i < log_d.size() && i < first_run.size(); i++)
            chk32("replay_same", log_d[i], first_run[i]);

        // Digest arriving mid-stream is dropped and flagged
        start_stream();
        run_stream(1'b0, 5);
        digest_in     = '1;
        digest_valid  = 1'b1;
        sif.out_ready = 1'b1;
        cycle();
        digest_valid  = 1'b0;
        run_stream(1'b0, 0);
        check_fox_log("overrun_stream");
        chk1("overrun_set", overrun, 1'b1);
        hash_num = 5'd0;
        cycle();
        chk32("overrun_rd0", rd_data, 32'h18f4f4bd);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk1("clear_overrun", overrun, 1'b0);
        chk1("clear_have", have_digest, 1'b0);

        // Reset mid-stream at word 7
        load(FOX);
        start_stream();
        run_stream(1'b0, 7);
        chk32("pre_reset_word7", sif.out_data, fox_w[7]);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_valid", sif.out_valid, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_have", have_digest, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        hash_num = 5'd0;
        cycle();
        chk32("post_rst_rd0", rd_data, 32'h0);

        // clear wins over digest_valid in the same cycle
        load(FOX);
        clear        = 1'b1;
        digest_valid = 1'b1;
        digest_in    = '1;
        cycle();
        clear        = 1'b0;
        digest_valid = 1'b0;
        chk1("clr_dv_have", have_digest, 1'b0);
        hash_num = 5'd3;
        cycle();
        chk32("clr_dv_rd", rd_data, 32'h0);

        // Capture and stream start together in HELD: new digest is streamed
        load(FOX);
        digest_in    = ~FOX;
        digest_valid = 1'b1;
        stream_start = 1'b1;
        cycle();
        digest_valid = 1'b0;
        stream_start = 1'b0;
        chk32("cap_start_word0", sif.out_data, ~fox_w[0]);
        run_stream(1'b0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            digest_valid = ($urandom_range(15) == 0);
            if (digest_valid) begin
                for (int w = 0; w < 16; w++) rnd = {rnd[479:0], 32'($urandom)};
                digest_in = rnd;
            end
            stream_start  = ($urandom_range(7) == 0);
            clear         = ($urandom_range(60) == 0);
            sif.out_ready = 1'($urandom_range(1));
            hash_num      = 5'($urandom_range(31));
            cycle();
        end
        digest_valid = 1'b0;
        stream_start = 1'b0;
        clear        = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/keccak_digest_reader.md
Name: keccak_digest_reader

Overview:
Read-side companion to the keccak core's 32-bit message writer. It captures the 512-bit digest when the core signals completion and holds it in a local buffer. Software can read the buffer at random by word index (hash_num), or stream it out as 16 words over a valid/ready handshake. It sits between the keccak core output and the or1200_cpu_tmp datapath.

Parameters:
DIGEST_W, 512, digest width in bits
WORD_W, 32, output word width
NUM_WORDS, 16, DIGEST_W/WORD_W; the index/counter limit

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
digest_in  input  512  digest from keccak core; word 0 = bits [511:480]
digest_valid  input  1  one-cycle pulse: digest_in is valid this cycle
hash_num  input  5  random-access word index
rd_data  output  32  registered word selected by hash_num
have_digest  output  1  buffer holds a valid digest
stream_start  input  1  pulse: begin streaming the buffer
clear  input  1  pulse: invalidate buffer, clear overrun
out_data  output  32  stream word
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts the word
out_last  output  1  asserted with word NUM_WORDS-1
busy  output  1  streaming in progress
overrun  output  1  sticky: a digest arrived while streaming and was dropped

Behaviour:
- Reset (async, rst=1):
  - state=EMPTY; buffer=0.
  - All outputs 0: rd_data, have_digest, out_data, out_valid, out_last, busy, overrun.
  - Word counter = 0.
- States: EMPTY, HELD, STREAM.
- EMPTY:
  - digest_valid: capture digest_in next edge -> HELD; have_digest=1.
  - stream_start is ignored.
- HELD:
  - digest_valid: overwrite the buffer; stay in HELD.
  - stream_start (no digest_valid): counter=0 -> STREAM.
  - If digest_valid and stream_start arrive together: capture first, then start streaming the new digest.
- STREAM:
  - out_valid=1; out_data = buffer word[counter]; out_last=(counter==NUM_WORDS-1); busy=1.
  - Word transfer occurs when out_valid && out_ready.
  - On transfer: counter+1. The transfer with out_last -> HELD; buffer is retained for re-stream.
  - out_data and out_valid are stable while out_ready=0 (AXI-style, no retraction).
  - digest_valid while in STREAM: digest dropped, buffer unchanged, overrun<=1 (sticky).
  - stream_start while in STREAM: ignored.
- clear, any state:
  - Next edge -> EMPTY; have_digest=0, overrun=0, counter=0; out_valid drops.
  - clear has priority over digest_valid and stream_start in the same cycle.
- Random access:
  - rd_data <= (hash_num<NUM_WORDS) ? word[hash_num] : 0 every cycle; latency 1 clock.
  - Reads are independent of state and never disturb the stream.
  - In EMPTY, rd_data returns the buffer contents (0 after reset or clear).
- Word mapping: word[i] = buffer[DIGEST_W-1-i*WORD_W -: WORD_W]. No byte swapping.
- Counter width: ceil(log2(NUM_WORDS)). It wraps to 0 after the last word.
- Reset mid-stream: immediate return to the reset state. No partial handshake completes.

Test Plan:
- Reset, then hash_num=0..31 -> rd_data=0, have_digest=0, out_valid=0 throughout.
- Pulse digest_valid with the SHA3-512 digest of "The quick brown fox jumps over the lazy dog." (18f4f4bd…ba6460f8):
  - hash_num=0 -> rd_data=32'h18f4f4bd one cycle later.
  - hash_num=15 -> rd_data=32'hba6460f8.
  - hash_num=16 -> rd_data=0.
- Stream with out_ready=1 constantly -> 16 consecutive words, word0=32'h18f4f4bd, out_last only on 32'hba6460f8, then busy=0 and have_digest=1.
- Stream with out_ready toggling 1,0,0,1,…:
  - out_data held stable while stalled.
  - Exactly 16 transfers.
  - Issuing stream_start again replays the identical sequence.
- digest_valid (all-ones digest) at word 5 of a stream:
  - Stream completes with the original words.
  - overrun=1.
  - rd_data[0] still 32'h18f4f4bd.
  - A subsequent clear -> overrun=0, have_digest=0.
- Assert rst mid-stream at word 7 -> out_valid=0 asynchronously, buffer=0, state EMPTY. Simultaneous clear+digest_valid -> EMPTY.
